gpr_mp_scbd: RTL and testbench

//  Parametrised multi-port general-purpose register file with an integrated

---
 rtl/gpr_mp_scbd.sv | 78 +++++++
 tb/tb_gpr_mp_scbd.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gpr_mp_scbd.sv
// gpr_mp_scbd: multi-port register file with write bypass and pending-write scoreboard
module gpr_mp_scbd #(
  parameter int XLEN = 32,
  parameter int REG_NUM = 32,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  localparam int AW = $clog2(REG_NUM)
) (
  input  logic                     clk_i,
  input  logic                     n_rst_i,
  input  logic [WR_PORTS-1:0]      we_i,
  input  logic [WR_PORTS*AW-1:0]   wa_i,
  input  logic [WR_PORTS*XLEN-1:0] wd_i,
  input  logic [RD_PORTS-1:0]      re_i,
  input  logic [RD_PORTS*AW-1:0]   ra_i,
  output logic [RD_PORTS*XLEN-1:0] rd_o,
  output logic [RD_PORTS-1:0]      rdy_o,
  input  logic                     alloc_i,
  input  logic [AW-1:0]            alloc_a_i,
  input  logic                     flush_i,
  output logic [REG_NUM-1:0]       busy_o,
  output logic [AW:0]              pend_cnt_o
);
  logic [XLEN-1:0]    r_regs [REG_NUM];
  logic [REG_NUM-1:0] r_busy;
  logic [AW:0]        r_cnt;
  logic [REG_NUM-1:0] w_wr_hit;
  logic [XLEN-1:0]    w_wr_data [REG_NUM];
  logic [REG_NUM-1:0] w_alloc;
  logic [REG_NUM-1:0] w_busy_nxt;
  logic [AW:0]        w_cnt;
  // later ports overwrite earlier ones, giving the higher index priority
  always_comb begin
    w_wr_hit = '0;
    for (int r = 0; r < REG_NUM; r++) begin
      w_wr_data[r] = '0;
      for (int k = 0; k < WR_PORTS; k++)
        if (we_i[k] && wa_i[k*AW+:AW] == AW'(r)) begin
          w_wr_hit[r] = 1'b1;
          w_wr_data[r] = wd_i[k*XLEN+:XLEN];
        end
    end
  end
  always_comb begin
    w_alloc = alloc_i ? (REG_NUM'(1) << alloc_a_i) : '0;
    w_busy_nxt = ((r_busy & ~w_wr_hit & {REG_NUM{!flush_i}}) | w_alloc) & ~REG_NUM'(1);
    w_cnt = '0;
    for (int i = 0; i < REG_NUM; i++)
      w_cnt = w_cnt + (AW+1)'(w_busy_nxt[i]);
  end
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (!n_rst_i)
      for (int r = 0; r < REG_NUM; r++)
        r_regs[r] <= '0;
    else
      for (int r = 1; r < REG_NUM; r++)
        if (w_wr_hit[r])
          r_regs[r] <= w_wr_data[r];
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (!n_rst_i) begin
      r_busy <= '0;
      r_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt <= w_cnt;
    end
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_pass;
    assign w_a = ra_i[p*AW+:AW];
    assign w_pass = !re_i[p] || w_a == '0;
    assign rd_o[p*XLEN+:XLEN] = (!n_rst_i || w_pass) ? '0 :
                                w_wr_hit[w_a] ? w_wr_data[w_a] : r_regs[w_a];
    assign rdy_o[p] = n_rst_i && (w_pass || !r_busy[w_a] || w_wr_hit[w_a]);
  end
  assign busy_o = r_busy;
  assign pend_cnt_o = r_cnt;
endmodule

// File: tb/tb_gpr_mp_scbd.sv
// tb_gpr_mp_scbd: directed and random checks of gpr_mp_scbd against a behavioural model
module tb_gpr_mp_scbd;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  we, re, rdy;
  logic [9:0]  wa, ra;
  logic [63:0] wd, rd;
  logic        alloc, flush;
  logic [4:0]  alloc_a;
  logic [31:0] busy;
  logic [5:0]  cnt;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  always #5 clk = ~clk;
  gpr_mp_scbd dut (
    .clk_i(clk), .n_rst_i(n_rst), .we_i(we), .wa_i(wa), .wd_i(wd),
    .re_i(re), .ra_i(ra), .rd_o(rd), .rdy_o(rdy), .alloc_i(alloc),
    .alloc_a_i(alloc_a), .flush_i(flush), .busy_o(busy), .pend_cnt_o(cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(int p);
    logic [4:0] a = ra[p*5+:5];
    if (!n_rst || !re[p] || a == 0) return 0;
    for (int k = 1; k >= 0; k--)
      if (we[k] && wa[k*5+:5] == a) return wd[k*32+:32];
    return m_regs[a];
  endfunction
  function automatic logic exp_rdy(int p);
    logic [4:0] a = ra[p*5+:5];
    if (!n_rst) return 0;
    if (!re[p] || a == 0 || !m_busy[a]) return 1;
    for (int k = 0; k < 2; k++)
      if (we[k] && wa[k*5+:5] == a) return 1;
    return 0;
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 0;
      m_busy[i] = 0;
    end
  endtask
  task automatic model_edge();
    for (int k = 0; k < 2; k++)
      if (we[k] && wa[k*5+:5] != 0) m_regs[wa[k*5+:5]] = wd[k*32+:32];
    if (flush)
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    for (int k = 0; k < 2; k++)
      if (we[k]) m_busy[wa[k*5+:5]] = 0;
    if (alloc && alloc_a != 0) m_busy[alloc_a] = 1;
  endtask
  task automatic check_all();
    logic [31:0] eb = 0;
    int ec = 0;
    for (int i = 1; i < 32; i++) begin
      eb[i] = m_busy[i];
      ec += int'(m_busy[i]);
    end
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rd%0d", p), 64'(rd[p*32+:32]), 64'(exp_rd(p)));
      chk($sformatf("rdy%0d", p), 64'(rdy[p]), 64'(exp_rdy(p)));
    end
    chk("busy", 64'(busy), 64'(eb));
    chk("cnt", 64'(cnt), 64'(ec));
  endtask
  task automatic idle();
    we = 0; wa = 0; wd = 0; re = 0; ra = 0;
    alloc = 0; alloc_a = 0; flush = 0;
  endtask
  task automatic step();
    #2;
    if (!n_rst) model_clear();
    check_all();
    @(posedge clk);
    if (n_rst) model_edge();
    @(negedge clk);
  endtask
  task automatic wr(int k, logic [4:0] a, logic [31:0] d);
    we[k] = 1; wa[k*5+:5] = a; wd[k*32+:32] = d;
  endtask
  task automatic rdp(int p, logic [4:0] a);
    re[p] = 1; ra[p*5+:5] = a;
  endtask
  initial begin
    n_rst = 0;
    idle();
    model_clear();
    @(negedge clk);
    rdp(0, 5); step();
    n_rst = 1;
    // write x5 then assert reset between edges
    idle(); wr(0, 5, 32'hDEAD); step();
    idle(); rdp(0, 5);
    #2 chk("x5_before_rst", 64'(rd[31:0]), 64'hDEAD);
    n_rst = 0;
    #1 chk("x5_in_rst", 64'(rd[31:0]), 64'h0);
    chk("rdy_in_rst", 64'(rdy), 64'h0);
    model_clear();
    @(negedge clk);
    step();
    n_rst = 1;
    idle(); rdp(0, 5); step();
    // dual write to x7, higher port wins
    idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rdp(1, 7);
    #1 chk("x7_bypass", 64'(rd[63:32]), 64'h22);
    step();
    idle(); rdp(0, 7); step();
    // alloc x3, writeback at cycle 3
    idle(); alloc = 1; alloc_a = 3; step();
    idle(); rdp(0, 3);
    #1 chk("x3_not_rdy", 64'(rdy[0]), 64'h0);
    step();
    idle(); rdp(0, 3); step();
    idle(); rdp(0, 3); wr(1, 3, 32'h5);
    #1 chk("x3_wb_rdy", 64'(rdy[0]), 64'h1);
    chk("x3_wb_data", 64'(rd[31:0]), 64'h5);
    step();
    idle(); rdp(0, 3);
    #1 chk("x3_busy_clr", 64'(busy[3]), 64'h0);
    step();
    // same-cycle write and alloc to x9
    idle(); wr(0, 9, 32'hCAFE); alloc = 1; alloc_a = 9; step();
    idle(); rdp(0, 9); rdp(1, 9);
    #1 chk("x9_busy", 64'(busy[9]), 64'h1);
    step();
    // fill then flush with concurrent alloc
    idle(); alloc = 1; alloc_a = 1; step();
    idle(); alloc = 1; alloc_a = 2; step();
    idle(); alloc = 1; alloc_a = 4; flush = 0; step();
    idle(); flush = 1; alloc = 1; alloc_a = 6;
    #1 chk("cnt3", 64'(cnt), 64'd4);
    step();
    idle();
    #1 chk("flush_busy", 64'(busy), 64'h40);
    chk("flush_cnt", 64'(cnt), 64'd1);
    step();
    // x0 writes and allocs are dropped
    idle(); wr(1, 0, 32'hFFFF); alloc = 1; alloc_a = 0; rdp(0, 0);
    #1 chk("x0_rd", 64'(rd[31:0]), 64'h0);
    step();
    idle(); rdp(0, 0); wr(0, 6, 32'h1);
    #1 chk("x0_busy", 64'(busy[0]), 64'h0);
    step();
    idle(); ra = {5'd7, 5'd3}; step();
    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      we = 2'($urandom);
      re = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        wa[k*5+:5] = 5'($urandom_range(0, 9));
        wd[k*32+:32] = $urandom;
        ra[k*5+:5] = 5'($urandom_range(0, 9));
      end
      alloc = ($urandom_range(0, 2) == 0);
      alloc_a = 5'($urandom_range(0, 9));
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
